// File: rtl/fir_transposed_prog.sv
// Programmable transposed-form FIR with shadow/active coefficient banks,
// valid-qualified streaming and a round-half-up, saturating output stage.
module fir_transposed_prog #(
  parameter int G_TAPS  = 8,
  parameter int G_I_W   = 16,
  parameter int G_T_W   = 16,
  parameter int G_O_W   = 16,
  parameter int G_SHIFT = 15
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_valid,
  input  logic [G_I_W-1:0]            i_sample,
  input  logic                        i_flush,
  input  logic                        i_coeff_we,
  input  logic [$clog2(G_TAPS)-1:0]   i_coeff_addr,
  input  logic [G_T_W-1:0]            i_coeff_data,
  input  logic                        i_coeff_commit,
  output logic [G_O_W-1:0]            o_result,
  output logic                        o_valid,
  output logic                        o_sat
);

  localparam int G_ACC_W = G_I_W + G_T_W + $clog2(G_TAPS);
  localparam int G_A_W   = $clog2(G_TAPS);

  localparam logic signed [G_ACC_W:0] C_ONE = (G_ACC_W+1)'(1);
  localparam logic signed [G_ACC_W:0] C_RND = (C_ONE << G_SHIFT) >> 1;
  localparam logic signed [G_ACC_W:0] C_MAX = (C_ONE << (G_O_W-1)) - C_ONE;
  localparam logic signed [G_ACC_W:0] C_MIN = -C_MAX - C_ONE;
  localparam logic [G_O_W-1:0] C_MAX_O = {1'b0, {(G_O_W-1){1'b1}}};
  localparam logic [G_O_W-1:0] C_MIN_O = {1'b1, {(G_O_W-1){1'b0}}};

  logic [G_T_W-1:0]   shadow_reg [G_TAPS];
  logic [G_T_W-1:0]   active_reg [G_TAPS];
  logic [G_ACC_W-1:0] prod       [G_TAPS];
  logic [G_ACC_W-1:0] z_reg      [1:G_TAPS-1];
  logic [G_ACC_W-1:0] acc_reg;
  logic [G_ACC_W-1:0] x_ext;
  logic [G_I_W-1:0]   x_reg;
  logic               v1_reg, v2_reg;
  logic [G_O_W-1:0]   result_reg, result_next;
  logic               valid_reg, sat_reg, sat_next;
  logic signed [G_ACC_W:0] rnd_sum, rnd_t;

  assign x_ext = {{(G_ACC_W-G_I_W){x_reg[G_I_W-1]}}, x_reg};

  genvar gi;
  generate
    for (gi = 0; gi < G_TAPS; gi++) begin : g_tap
      localparam logic [G_A_W-1:0] C_IDX = G_A_W'(gi);

      // Both operands are sign-extended to full width, so the truncated
      // product equals the true signed product.
      assign prod[gi] = {{(G_ACC_W-G_T_W){active_reg[gi][G_T_W-1]}}, active_reg[gi]} * x_ext;

      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          shadow_reg[gi] <= '0;
          active_reg[gi] <= '0;
        end else begin
          if (i_coeff_we && i_coeff_addr == C_IDX)
            shadow_reg[gi] <= i_coeff_data;
          if (i_coeff_commit)
            active_reg[gi] <= shadow_reg[gi];
        end
      end
    end

    for (gi = 1; gi < G_TAPS; gi++) begin : g_z
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
          z_reg[gi] <= '0;
        else if (i_flush)
          z_reg[gi] <= '0;
        else if (v1_reg) begin
          if (gi == G_TAPS-1)
            z_reg[gi] <= prod[gi];
          else
            z_reg[gi] <= prod[gi] + z_reg[(gi == G_TAPS-1) ? gi : gi+1];
        end
      end
    end
  endgenerate

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      x_reg   <= '0;
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      acc_reg <= '0;
    end else if (i_flush) begin
      v1_reg  <= 1'b0;
      v2_reg  <= 1'b0;
      acc_reg <= '0;
    end else begin
      v1_reg <= i_valid;
      v2_reg <= v1_reg;
      if (i_valid)
        x_reg <= i_sample;
      if (v1_reg)
        acc_reg <= prod[0] + z_reg[1];
    end
  end

  // Round-half-up then arithmetic shift; one guard bit keeps the add exact.
  assign rnd_sum = {acc_reg[G_ACC_W-1], acc_reg} + C_RND;
  assign rnd_t   = rnd_sum >>> G_SHIFT;

  always_comb begin
    result_next = rnd_t[G_O_W-1:0];
    sat_next    = 1'b0;
    if (rnd_t > C_MAX) begin
      result_next = C_MAX_O;
      sat_next    = 1'b1;
    end else if (rnd_t < C_MIN) begin
      result_next = C_MIN_O;
      sat_next    = 1'b1;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      result_reg <= '0;
      valid_reg  <= 1'b0;
      sat_reg    <= 1'b0;
    end else if (i_flush) begin
      valid_reg <= 1'b0;
      sat_reg   <= 1'b0;
    end else begin
      valid_reg <= v2_reg;
      sat_reg   <= v2_reg & sat_next;
      if (v2_reg)
        result_reg <= result_next;
    end
  end

  assign o_result = result_reg;
  assign o_valid  = valid_reg;
  assign o_sat    = sat_reg;

endmodule

// File: tb/tb_fir_transposed_prog.sv
// Randomised and directed bench for fir_transposed_prog against a
// sum-of-products reference model with per-sample coefficient snapshots.
module tb_fir_transposed_prog;

  localparam int TAPS = 8, I_W = 16, T_W = 16, O_W = 16, SHIFT = 15, A_W = 3;

  logic i_clk = 1'b0, i_rst = 1'b1;
  logic i_valid = 1'b0, i_flush = 1'b0, i_coeff_we = 1'b0, i_coeff_commit = 1'b0;
  logic [I_W-1:0] i_sample = '0;
  logic [A_W-1:0] i_coeff_addr = '0;
  logic [T_W-1:0] i_coeff_data = '0;
  logic [O_W-1:0] o_result;
  logic o_valid, o_sat;

  fir_transposed_prog #(.G_TAPS(TAPS), .G_I_W(I_W), .G_T_W(T_W), .G_O_W(O_W), .G_SHIFT(SHIFT)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_sample(i_sample), .i_flush(i_flush),
    .i_coeff_we(i_coeff_we), .i_coeff_addr(i_coeff_addr), .i_coeff_data(i_coeff_data),
    .i_coeff_commit(i_coeff_commit), .o_result(o_result), .o_valid(o_valid), .o_sat(o_sat)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0, failures = 0;

  task automatic check(string tag, longint got, longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: each accepted sample carries the active bank it was multiplied by.
  longint m_shadow [TAPS], m_active [TAPS];
  longint hist_x [TAPS];
  longint hist_h [TAPS][TAPS];
  bit     p1_v, p2_v, p2_sat, e_valid, e_sat;
  longint p1_x, p2_val, e_result;
  longint obs_q[$];
  bit     obs_sat_q[$];
  longint coef_buf [TAPS];

  function automatic void clear_hist();
    for (int i = 0; i < TAPS; i++) begin
      hist_x[i] = 0;
      for (int k = 0; k < TAPS; k++) hist_h[i][k] = 0;
    end
    p1_v = 0; p2_v = 0;
  endfunction

  function automatic void model_reset();
    clear_hist();
    for (int k = 0; k < TAPS; k++) begin m_shadow[k] = 0; m_active[k] = 0; end
    e_valid = 0; e_sat = 0; e_result = 0;
  endfunction

  function automatic void model_edge();
    longint sum, t;
    if (i_rst) begin model_reset(); return; end
    e_valid = p2_v && !i_flush;
    e_sat   = 0;
    if (e_valid) begin e_result = p2_val; e_sat = p2_sat; end
    if (i_flush) clear_hist();
    else begin
      if (p1_v) begin
        for (int i = TAPS-1; i > 0; i--) begin
          hist_x[i] = hist_x[i-1];
          for (int k = 0; k < TAPS; k++) hist_h[i][k] = hist_h[i-1][k];
        end
        hist_x[0] = p1_x;
        for (int k = 0; k < TAPS; k++) hist_h[0][k] = m_active[k];
        sum = 0;
        for (int k = 0; k < TAPS; k++) sum += hist_h[k][k] * hist_x[k];
        t = (sum + (longint'(1) <<< (SHIFT-1))) >>> SHIFT;
        p2_sat = (t > 32767) || (t < -32768);
        p2_val = (t > 32767) ? 32767 : (t < -32768) ? -32768 : t;
      end
      p2_v = p1_v;
      p1_v = i_valid;
      p1_x = longint'($signed(i_sample));
    end
    if (i_coeff_commit)
      for (int k = 0; k < TAPS; k++) m_active[k] = m_shadow[k];
    if (i_coeff_we) m_shadow[i_coeff_addr] = longint'($signed(i_coeff_data));
  endfunction

  task automatic check_outputs();
    check("o_valid", o_valid, e_valid);
    check("o_result", longint'($signed(o_result)), e_result);
    check("o_sat", o_sat, e_sat);
    if (o_valid) begin
      obs_q.push_back(longint'($signed(o_result)));
      obs_sat_q.push_back(o_sat);
      $display("t=%0t out=%0d sat=%0b exp=%0d", $time, $signed(o_result), o_sat, e_result);
    end
  endtask

  // Called at a falling edge; drives inputs, advances one rising edge, checks.
  task automatic step(bit v, longint s, bit fl = 0, bit we = 0, int addr = 0, longint d = 0, bit cm = 0);
    i_valid = v; i_sample = I_W'(s); i_flush = fl;
    i_coeff_we = we; i_coeff_addr = A_W'(addr); i_coeff_data = T_W'(d); i_coeff_commit = cm;
    @(posedge i_clk);
    model_edge();
    #1 check_outputs();
    @(negedge i_clk);
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic load_bank();
    for (int k = 0; k < TAPS; k++) step(0, 0, 0, 1, k, coef_buf[k]);
    step(0, 0, 0, 0, 0, 0, 1);
  endtask

  task automatic impulse(longint amp);
    step(1, amp);
    for (int i = 0; i < TAPS-1; i++) step(1, 0);
    idle(4);
  endtask

  task automatic expect_obs(string tag, longint scale, bit descend);
    check({tag, "_cnt"}, obs_q.size(), TAPS);
    for (int i = 0; i < TAPS && i < obs_q.size(); i++)
      check(tag, obs_q[i], scale * (descend ? (TAPS - i) : (i + 1)));
  endtask

  initial begin
    logic signed [15:0] rs, rd;
    model_reset();
    @(negedge i_clk);
    #1 check("rst_result", longint'($signed(o_result)), 0);
    check("rst_valid", o_valid, 0);
    check("rst_sat", o_sat, 0);
    step(0, 0); step(1, 5);
    i_rst = 1'b0;

    // Impulse response with explicit latency check.
    for (int k = 0; k < TAPS; k++) coef_buf[k] = (k + 1) * 1024;
    load_bank();
    obs_q.delete();
    step(1, 32); step(1, 0);
    check("lat_e1", o_valid, 0);
    step(1, 0);
    check("lat_e2", o_valid, 1);
    for (int i = 0; i < TAPS-3; i++) step(1, 0);
    idle(4);
    expect_obs("impulse", 1, 0);

    // Gapped stream, one sample every third cycle.
    obs_q.delete();
    step(1, 3200); idle(2);
    for (int i = 0; i < TAPS-1; i++) begin step(1, 0); idle(2); end
    idle(4);
    expect_obs("gapped", 100, 0);

    // Saturation high and low, then rounding on a single tap.
    for (int k = 0; k < TAPS; k++) coef_buf[k] = 32767;
    load_bank();
    obs_q.delete(); obs_sat_q.delete();
    for (int i = 0; i < 10; i++) step(1, 32767);
    idle(3);
    check("sat_hi", obs_q[$], 32767);
    check("sat_hi_flag", obs_sat_q[$], 1);
    for (int i = 0; i < 10; i++) step(1, -32768);
    idle(3);
    check("sat_lo", obs_q[$], -32768);
    check("sat_lo_flag", obs_sat_q[$], 1);
    for (int k = 0; k < TAPS; k++) coef_buf[k] = (k == 0) ? 16384 : 0;
    load_bank();
    for (int i = 0; i < TAPS; i++) step(1, 0);
    idle(3);
    obs_q.delete(); obs_sat_q.delete();
    step(1, 1); idle(3);
    check("round_half", obs_q.size() > 0 ? obs_q[0] : -1, 1);
    check("round_flag", obs_sat_q.size() > 0 ? obs_sat_q[0] : 1, 0);

    // Shadow writes during a run leave the active bank untouched.
    for (int k = 0; k < TAPS; k++) coef_buf[k] = (k + 1) * 1024;
    load_bank();
    obs_q.delete();
    step(1, 32);
    for (int k = 0; k < TAPS; k++) step(1, 0, 0, 1, k, (TAPS - k) * 1024);
    idle(3);
    while (obs_q.size() > TAPS) void'(obs_q.pop_back());
    expect_obs("shadow_iso", 1, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    obs_q.delete();
    impulse(32);
    expect_obs("commit_b", 1, 1);
    step(0, 0, 0, 1, 0, 5 * 1024, 1);
    obs_q.delete();
    impulse(32);
    check("we_commit_old", obs_q.size() > 0 ? obs_q[0] : -1, TAPS);
    step(0, 0, 0, 0, 0, 0, 1);
    obs_q.delete();
    impulse(32);
    check("we_commit_new", obs_q.size() > 0 ? obs_q[0] : -1, 5);

    // Flush with i_valid high drops that sample and all history.
    for (int k = 0; k < TAPS; k++) coef_buf[k] = (k + 1) * 1024;
    load_bank();
    for (int i = 1; i <= 6; i++) step(1, i * 100);
    step(1, 999, 1);
    check("flush_ov", o_valid, 0);
    obs_q.delete();
    idle(2);
    impulse(32);
    expect_obs("post_flush", 1, 0);

    // Random traffic including flushes, writes and commits.
    for (int i = 0; i < 400; i++) begin
      rs = 16'($urandom);
      rd = 16'($signed(16'($urandom)) >>> 2);
      step($urandom_range(0, 3) != 0, rs, $urandom_range(0, 40) == 0,
           $urandom_range(0, 3) == 0, $urandom_range(0, TAPS-1), rd,
           $urandom_range(0, 15) == 0);
    end

    // Asynchronous reset between edges while streaming.
    for (int i = 0; i < 5; i++) step(1, 1000 + i);
    i_valid = 1'b1; i_sample = 16'd123;
    #2 i_rst = 1'b1;
    model_reset();
    #1 check("arst_result", longint'($signed(o_result)), 0);
    check("arst_valid", o_valid, 0);
    check("arst_sat", o_sat, 0);
    @(posedge i_clk);
    model_edge();
    #1 check_outputs();
    @(negedge i_clk);
    i_rst = 1'b0;
    obs_q.delete();
    for (int i = 0; i < 5; i++) step(1, 12345);
    idle(4);
    check("arst_zero_cnt", obs_q.size(), 5);
    foreach (obs_q[i]) check("arst_zero", obs_q[i], 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
